// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// The FSM encoding lives here so the top and any wrapper agree on it.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead slice.
// All four carries are derived from cin in parallel.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               c4
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c4   = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial adder: one shared CLA slice, LSB nibble first,
// carry registered between steps, valid/ready on both sides.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = $clog2(NSLICE);
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_c4;

  assign sl_a = op_a_q[SLICE_W*idx_q +: SLICE_W];
  assign sl_b = op_b_q[SLICE_W*idx_q +: SLICE_W];

  cla4_slice u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .c4  (sl_c4)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = sl_s;
        carry_d = sl_c4;
        if (idx_q == LAST) begin
          cout_d  = sl_c4;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
